// File: rtl/uart_debug_bridge.sv
// Host debug monitor: decodes UART command bytes and performs 16-bit bus reads/writes
// while holding bus ownership (csu), returning read data or a status byte to the host.
module uart_debug_bridge #(
  parameter int ACCESS_CYCLES = 4,
  parameter int TX_GAP        = 4340
) (
  input  logic        clk,
  input  logic        nreset,
  input  logic        dix,
  output logic        dox,
  input  logic [7:0]  id,
  output logic [7:0]  od,
  output logic        csu,
  output logic [15:0] addru,
  output logic        ru,
  output logic [1:0]  wru,
  input  logic [15:0] rdata,
  output logic [15:0] datau,
  input  logic [7:0]  status
);

  localparam int AW = $clog2(ACCESS_CYCLES + 1);
  localparam int GW = $clog2(TX_GAP + 1);

  localparam logic [7:0] OP_SETADDR = 8'h01;
  localparam logic [7:0] OP_WRWORD  = 8'h02;
  localparam logic [7:0] OP_WRBYTE  = 8'h03;
  localparam logic [7:0] OP_RDWORD  = 8'h04;
  localparam logic [7:0] OP_STATUS  = 8'h05;

  typedef enum logic [2:0] {
    S_IDLE, S_HI, S_LO, S_STAT, S_ACC, S_TX
  } state_t;

  state_t          state, state_n;
  logic [7:0]      opcode;
  logic [7:0]      hi_byte;
  logic [15:0]     addr_a;
  logic [AW-1:0]   acc_cnt;
  logic [GW-1:0]   gap_cnt;
  logic [7:0]      tx_lo;
  logic [1:0]      tx_left;
  logic            acc_last;

  assign acc_last = (acc_cnt == AW'(ACCESS_CYCLES - 1));

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) state <= S_IDLE;
    else         state <= state_n;
  end

  always_comb begin
    state_n = state;
    csu     = 1'b0;
    ru      = 1'b0;
    wru     = 2'b00;
    dox     = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (dix) begin
          case (id)
            OP_SETADDR, OP_WRWORD: state_n = S_HI;
            OP_WRBYTE:             state_n = S_LO;
            OP_RDWORD:             state_n = S_ACC;
            OP_STATUS:             state_n = S_STAT;
            default:               state_n = S_IDLE;
          endcase
        end
      end
      S_HI:   if (dix) state_n = S_LO;
      S_LO:   if (dix) state_n = (opcode == OP_SETADDR) ? S_IDLE : S_ACC;
      S_STAT: state_n = S_TX;
      S_ACC: begin
        csu = 1'b1;
        ru  = (opcode == OP_RDWORD);
        if (opcode == OP_WRWORD)      wru = 2'b11;
        else if (opcode == OP_WRBYTE) wru = addr_a[0] ? 2'b01 : 2'b10;
        if (acc_last) state_n = (opcode == OP_RDWORD) ? S_TX : S_IDLE;
      end
      S_TX: begin
        if (gap_cnt == '0) begin
          dox = 1'b1;
          if (tx_left == 2'd1) state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      opcode  <= '0;
      hi_byte <= '0;
      addr_a  <= '0;
      acc_cnt <= '0;
      gap_cnt <= '0;
      tx_lo   <= '0;
      tx_left <= '0;
      addru   <= '0;
      datau   <= '0;
      od      <= '0;
    end else begin
      // gap counter spans command boundaries so back-to-back replies stay a frame apart
      if (dox)                gap_cnt <= GW'(TX_GAP - 1);
      else if (gap_cnt != '0) gap_cnt <= gap_cnt - 1'b1;

      case (state)
        S_IDLE: if (dix) opcode <= id;
        S_HI:   if (dix) hi_byte <= id;
        S_LO: begin
          if (dix) begin
            if (opcode == OP_SETADDR)     addr_a <= {hi_byte, id};
            else if (opcode == OP_WRWORD) datau  <= {hi_byte, id};
            else                          datau  <= {id, id};
          end
        end
        S_STAT: begin
          od      <= status;
          tx_left <= 2'd1;
        end
        S_ACC: begin
          acc_cnt <= acc_cnt + 1'b1;
          if (acc_last) begin
            addr_a <= addr_a + ((opcode == OP_WRBYTE) ? 16'd1 : 16'd2);
            if (opcode == OP_RDWORD) begin
              od      <= rdata[15:8];
              tx_lo   <= rdata[7:0];
              tx_left <= 2'd2;
            end
          end
        end
        S_TX: begin
          if (dox) begin
            od      <= tx_lo;
            tx_left <= tx_left - 1'b1;
          end
        end
        default: ;
      endcase

      if (state != S_ACC && state_n == S_ACC) begin
        addru   <= {addr_a[15:1], 1'b0};
        acc_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_uart_debug_bridge.sv
// Randomized bench for uart_debug_bridge: a command-level model predicts bus accesses and
// reply bytes, which are compared with what monitors observe on the DUT pins.
module tb_uart_debug_bridge;

  localparam int AC  = 4;
  localparam int GAP = 20;

  logic        clk = 1'b0;
  logic        nreset = 1'b0;
  logic        dix = 1'b0;
  logic        dox;
  logic [7:0]  id = 8'h00;
  logic [7:0]  od;
  logic        csu;
  logic [15:0] addru;
  logic        ru;
  logic [1:0]  wru;
  logic [15:0] rdata = 16'h0000;
  logic [15:0] datau;
  logic [7:0]  status = 8'h00;

  always #5 clk = ~clk;

  uart_debug_bridge #(.ACCESS_CYCLES(AC), .TX_GAP(GAP)) dut (
    .clk(clk), .nreset(nreset), .dix(dix), .dox(dox), .id(id), .od(od),
    .csu(csu), .addru(addru), .ru(ru), .wru(wru), .rdata(rdata),
    .datau(datau), .status(status)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [15:0] addr;
    logic [15:0] data;
    logic        rd;
    logic [1:0]  we;
  } acc_t;

  acc_t       acc_q[$];
  logic [7:0] tx_q[$];

  int   cyc = 0;
  int   last_dox = 0;
  bit   have_dox = 0;
  bit   in_acc = 0;
  int   acc_len = 0;
  acc_t cur;

  // pin monitors: record each completed access and each transmitted byte
  always @(negedge clk) begin
    cyc++;
    if (!nreset) begin
      in_acc   = 0;
      have_dox = 0;
    end else begin
      if (csu) begin
        if (!in_acc) begin
          in_acc  = 1;
          acc_len = 0;
          cur     = '{addru, datau, ru, wru};
        end
        acc_len++;
      end else if (in_acc) begin
        in_acc = 0;
        check("acc_len", acc_len, AC);
        check("strobes_off", {ru, wru}, 0);
        acc_q.push_back(cur);
      end
      if (dox) begin
        check("dox_in_access", csu, 0);
        if (have_dox) check("tx_gap", (cyc - last_dox) >= GAP, 1);
        have_dox = 1;
        last_dox = cyc;
        tx_q.push_back(od);
      end
    end
  end

  logic [15:0] m_addr = 16'h0000;
  logic [15:0] m_data = 16'h0000;
  bit          drop_next = 0;

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    id  = b;
    dix = 1'b1;
    @(negedge clk);
    dix = 1'b0;
    id  = 8'($urandom);
    repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  // For RDWORD, b1/b2 are the bus read data; for STATUS, b1 is the status byte.
  task automatic do_cmd(input logic [7:0] op, input logic [7:0] b1, input logic [7:0] b2);
    acc_t       e_acc[$];
    logic [7:0] e_tx[$];
    int         guard;
    acc_q.delete();
    tx_q.delete();
    case (op)
      8'h01: begin
        m_addr = {b1, b2};
        send_byte(op); send_byte(b1); send_byte(b2);
      end
      8'h02: begin
        m_data = {b1, b2};
        e_acc.push_back('{m_addr & 16'hFFFE, m_data, 1'b0, 2'b11});
        m_addr = m_addr + 16'd2;
        send_byte(op); send_byte(b1);
        if (drop_next) begin
          @(negedge clk); id = b2; dix = 1'b1;
          @(negedge clk); id = 8'h05;
          @(negedge clk); dix = 1'b0;
        end else send_byte(b2);
      end
      8'h03: begin
        m_data = {b1, b1};
        e_acc.push_back('{m_addr & 16'hFFFE, m_data, 1'b0, m_addr[0] ? 2'b01 : 2'b10});
        m_addr = m_addr + 16'd1;
        send_byte(op); send_byte(b1);
      end
      8'h04: begin
        rdata = {b1, b2};
        e_acc.push_back('{m_addr & 16'hFFFE, m_data, 1'b1, 2'b00});
        e_tx.push_back(b1);
        e_tx.push_back(b2);
        m_addr = m_addr + 16'd2;
        send_byte(op);
      end
      8'h05: begin
        status = b1;
        e_tx.push_back(b1);
        send_byte(op);
      end
      default: send_byte(op);
    endcase
    guard = 0;
    while ((acc_q.size() < e_acc.size() || tx_q.size() < e_tx.size()) && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    repeat (AC + 3) @(negedge clk);
    check("acc_count", acc_q.size(), e_acc.size());
    for (int i = 0; i < e_acc.size(); i++) begin
      if (i < acc_q.size()) begin
        check("acc_addr", acc_q[i].addr, e_acc[i].addr);
        check("acc_data", acc_q[i].data, e_acc[i].data);
        check("acc_ru",   acc_q[i].rd,   e_acc[i].rd);
        check("acc_wru",  acc_q[i].we,   e_acc[i].we);
      end
    end
    check("tx_count", tx_q.size(), e_tx.size());
    for (int i = 0; i < e_tx.size(); i++) begin
      if (i < tx_q.size()) check("tx_byte", tx_q[i], e_tx[i]);
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    #1;
    check("rst_csu", csu, 0);
    check("rst_ru", ru, 0);
    check("rst_wru", wru, 0);
    check("rst_addru", addru, 0);
    check("rst_datau", datau, 0);
    check("rst_od", od, 0);
    check("rst_dox", dox, 0);
    repeat (3) @(negedge clk);
    nreset = 1'b1;
    repeat (2) @(negedge clk);

    do_cmd(8'h01, 8'h20, 8'h00); do_cmd(8'h02, 8'h12, 8'h34);
    do_cmd(8'h01, 8'h20, 8'h00); do_cmd(8'h04, 8'h12, 8'h34);
    do_cmd(8'h01, 8'h20, 8'h01); do_cmd(8'h03, 8'hAB, 8'h00); do_cmd(8'h03, 8'hCD, 8'h00);
    do_cmd(8'h01, 8'hFF, 8'hFE); do_cmd(8'h02, 8'h00, 8'h01); do_cmd(8'h02, 8'h00, 8'h02);
    do_cmd(8'h01, 8'hFF, 8'hFF); do_cmd(8'h03, 8'h11, 8'h00); do_cmd(8'h03, 8'h22, 8'h00);
    do_cmd(8'h7F, 8'h00, 8'h00); do_cmd(8'h05, 8'h25, 8'h00);
    do_cmd(8'h01, 8'h20, 8'h00);
    drop_next = 1;
    do_cmd(8'h02, 8'h56, 8'h78);
    drop_next = 0;
    do_cmd(8'h04, 8'h9A, 8'hBC);

    // abort in the middle of a write access
    do_cmd(8'h01, 8'h20, 8'h00);
    send_byte(8'h02); send_byte(8'h12);
    @(negedge clk); id = 8'h34; dix = 1'b1;
    @(negedge clk); dix = 1'b0;
    #2 nreset = 1'b0;
    #1;
    check("abort_csu", csu, 0);
    check("abort_wru", wru, 0);
    check("abort_ru", ru, 0);
    check("abort_dox", dox, 0);
    repeat (3) @(negedge clk);
    check("abort_datau", datau, 0);
    check("abort_addru", addru, 0);
    nreset = 1'b1;
    m_addr = 16'h0000;
    m_data = 16'h0000;
    do_cmd(8'h01, 8'h30, 8'h00);
    do_cmd(8'h04, 8'hA5, 8'h5A);

    for (int n = 0; n < 80; n++) begin
      logic [7:0] r1, r2, op;
      r1 = 8'($urandom);
      r2 = 8'($urandom);
      case ($urandom_range(0, 6))
        0: op = 8'h01;
        1: op = 8'h02;
        2: op = 8'h03;
        3: op = 8'h04;
        4: op = 8'h05;
        5: op = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(6, 255));
        default: op = 8'h04;
      endcase
      do_cmd(op, r1, r2);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/uart_debug_bridge.md
Name: uart_debug_bridge

Overview:
- Byte-oriented debug monitor between a UART byte interface and the system memory/register bus.
- Decodes host command bytes and takes over the bus (csu) to perform 16-bit reads/writes.
- Returns read data and an 8-bit status byte to the host.
- Sits beside the CPU; while csu=1 the top level muxes addru/datau/ru/wru onto the bus and stalls the CPU.

Parameters:
- ACCESS_CYCLES, 4, clocks csu and the bus strobes are held per bus access (min 2).
- TX_GAP, 4340, minimum clocks between successive dox pulses (one UART frame at the chosen baud).

Ports:
- clk  in  1  system clock, all logic on posedge.
- nreset  in  1  asynchronous, active-low reset.
- dix  in  1  one-cycle strobe: received byte valid on id.
- dox  out  1  one-cycle strobe: od holds a byte to transmit.
- id  in  8  received byte.
- od  out  8  byte to transmit.
- csu  out  1  bus ownership request; high only during an access.
- addru  out  16  bus byte address.
- ru  out  1  read strobe.
- wru  out  2  write byte enables; [1] = high byte, [0] = low byte.
- rdata  in  16  bus read data, sampled on the last access cycle.
- datau  out  16  bus write data.
- status  in  8  status byte, returned verbatim by the status command.

Behaviour:
- Reset values: csu=0, addru=0, ru=0, wru=00, datau=0, od=0, dox=0, FSM=IDLE, TX gap counter=0.
- IDLE: on dix, latch id as opcode. Unknown opcodes are ignored and the FSM stays in IDLE.
- 0x01 SETADDR: next 2 bytes (hi, lo) load addressA. No bus access, no reply.
- 0x02 WRWORD: next 2 bytes (hi, lo) form datau; access uses wru=11, addru=addressA&FFFE; then addressA+=2.
- 0x03 WRBYTE: next byte replicated to datau[15:8] and datau[7:0].
  - Big-endian lanes: wru=10 if addressA[0]=0, wru=01 if addressA[0]=1.
  - Then addressA+=1.
- 0x04 RDWORD: access with ru=1, addru=addressA&FFFE; then addressA+=2.
  - Reply rdata[15:8], then rdata[7:0].
- 0x05 STATUS: reply 1 byte = status, sampled in the cycle after the opcode is received. No bus access.
- Operand bytes are collected in order; state returns to IDLE after the command completes.
- Access phase:
  - csu, addru, datau, ru/wru are driven together for exactly ACCESS_CYCLES clocks.
  - rdata is captured on the final cycle.
  - The next clock deasserts csu, ru and wru; datau and addru keep their last values.
- Address arithmetic is modulo 2^16 (FFFF+1 = 0000, FFFE+2 = 0000).
- TX:
  - Each reply byte is presented on od with a single-cycle dox.
  - Consecutive dox pulses are at least TX_GAP clocks apart.
  - The first reply byte is issued no earlier than the clock after the access ends.
- dix pulses arriving during an access or reply transmission are dropped.
- Asynchronous reset mid-command or mid-access aborts immediately: csu, ru and wru drop to 0, and any pending reply is discarded.

Test Plan:
- Reset: assert nreset=0 mid-access -> csu=0, wru=00, dox=0 asynchronously; after release, FSM is in IDLE and SETADDR works.
- Write/read: send 01 20 00, 02 12 34 -> one access with addru=2000, wru=11, datau=1234, csu high ACCESS_CYCLES clocks. Then send 01 20 00, 04 with rdata=1234 -> ru access, dox bytes 12 then 34 spaced ≥TX_GAP.
- Byte lanes: 01 20 01, 03 AB -> addru=2000, wru=01, datau=ABAB, next address 2002. Issue 03 CD -> wru=10, addru=2002.
- Autoincrement wrap: 01 FF FE, 02 00 01, 02 00 02 -> second access at addru=0000.
- Status/unknown: send 7F then 05 with status=0x25 -> 7F ignored, single reply byte 25, no csu.
- Dropped input: a dix pulse during an access -> no effect; the following command executes normally.
